wokwi_414120248222232577: RTL and testbench
===========================================

# wokwi_414120248222232577

Tiny Tapeout user tile that implements a prescaled 8-bit up/down/load counter. The count is shown on the dedicated outputs either as raw binary or as a 7-segment hex digit with a wrap indicator. It sits directly behind the standard tile pin list. The bidirectional pins serve only as the parallel-load data input.

## Interface
Parameters: none.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-high (asserted when 1); port name kept from the tile pin list
- ena  in  1  tile-select; ignored, the design runs regardless
- ui_in  in  8  [1:0] mode, [4:2] prescale exponent n, [6:5] unused, [7] display select
- uio_in  in  8  parallel load value
- uo_out  out  8  display output
- uio_out  out  8  constant 8'h00
- uio_oe  out  8  constant 8'h00 (all bidirectional pins are inputs)

## Operation
- State:
  - cnt[7:0], the counter
  - pre[7:0], the prescaler
  - wrap, a sticky flag
- Mode ui_in[1:0]:
  - 00 hold
  - 01 count up
  - 10 count down
  - 11 load
- Prescale limit L = 2^n − 1, with n = ui_in[4:2]. L ranges from 0 to 127.
- Each edge with reset deasserted:
  - If mode = 11: cnt <= uio_in, pre <= 0, wrap <= 0. Load acts every cycle, independent of the prescaler.
  - Otherwise, if pre >= L: pre <= 0 and a tick occurs.
  - Otherwise: pre <= pre + 1, and cnt holds.
- On a tick:
  - Up: cnt <= cnt + 1 mod 256. The FF→00 transition sets wrap.
  - Down: cnt <= cnt − 1 mod 256. The 00→FF transition sets wrap.
  - Hold: cnt is unchanged.
- The prescaler runs in hold mode too.
- wrap stays set until reset or load.
- Display, combinational from state and ui_in[7]:
  - ui_in[7] = 0: uo_out = cnt.
  - ui_in[7] = 1: uo_out[6:0] = hex segments of cnt[3:0] and uo_out[7] = wrap.
- Segment encoding: bit0 = a … bit6 = g, active-high. Digits 0–F map to:
  - 0–7: 3F 06 5B 4F 66 6D 7D 07
  - 8–F: 7F 6F 77 7C 39 5E 79 71

## Timing
- Reset when rst_n = 1 on an edge: cnt = 0, pre = 0, wrap = 0.
- Outputs during and after reset:
  - uo_out = 8'h00 when ui_in[7] = 0, or 8'h3F when ui_in[7] = 1.
  - uio_out = 8'h00 and uio_oe = 8'h00 at all times.
- Reset dominates a simultaneous load or tick.
- Reset asserted mid-count clears all state on that edge.
- Latency:
  - A load or tick is visible on uo_out immediately after the edge that performs it.
  - The display select takes effect combinationally, with zero cycles latency.
- After reset release in count mode, the first tick happens on the 2^n-th edge. Subsequent ticks occur every 2^n edges.
- n = 0 gives a tick every edge.
- Reducing n mid-count while pre > new L forces a tick and pre clear on the next edge.
- Changing mode does not clear pre.
- Leaving load mode: pre starts from 0, so the first tick occurs 2^n edges later.

## Structure
- Shared package holds:
  - mode constants: MODE_HOLD, MODE_UP, MODE_DOWN, MODE_LOAD
  - the 16-entry segment constant table
- One sub-module, hex7seg: 4-bit in, 7-bit out, purely combinational.
- The top module holds the counter, prescaler, wrap flag and output mux.

## Test plan
- Reset with ui_in = 8'h80: uo_out = 8'h3F. Set ui_in = 8'h00: uo_out = 8'h00, and uio_oe = 8'h00 throughout.
- Mode 01, n = 0, run 5 edges after reset: uo_out = 8'h05.
- Load 8'hA5 (mode 11, uio_in = 8'hA5) for 1 edge, then mode 10, n = 0, for 3 edges: uo_out = 8'hA2.
- Load 8'hFE, then count up 2 edges with ui_in[7] = 1: cnt = 8'h00 and uo_out = 8'hBF (wrap set, segments "0"). A following load clears uo_out[7].
- Mode 01, n = 3: cnt stays 0 for 7 edges and becomes 1 on the 8th edge, then 2 on the 16th.
- Hold mode for 10 edges after load 8'h3C: uo_out stays 8'h3C. With ui_in[7] = 1, uo_out = 8'h39 ("C").

Source files
------------

// File: rtl/wokwi_414120248222232577_pkg.sv
// Shared definitions for the prescaled up/down/load counter tile.
package wokwi_414120248222232577_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Active-high segments, bit0 = a ... bit6 = g; index = hex digit.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,  // F..8
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F   // 7..0
  };

endpackage

// File: rtl/wokwi_414120248222232577_hex7seg.sv
// Combinational hex digit to 7-segment decoder.
module hex7seg
  import wokwi_414120248222232577_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern for one hex digit.
  always_comb begin
    seg_o = SEG_TABLE[digit_i];
  end

endmodule

// File: rtl/wokwi_414120248222232577.sv
// Tile top: prescaled 8-bit up/down/load counter with binary or 7-segment display.
module wokwi_414120248222232577
  import wokwi_414120248222232577_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pre_q, pre_d;
  logic       wrap_q, wrap_d;

  mode_e      mode;
  logic [2:0] exp_n;
  logic [7:0] pre_lim;
  logic       disp_sel;
  logic [6:0] seg;

  // ena and ui_in[6:5] have no function in this tile.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, ui_in[6:5]};

  assign mode     = mode_e'(ui_in[1:0]);
  assign exp_n    = ui_in[4:2];
  assign pre_lim  = (8'd1 << exp_n) - 8'd1;
  assign disp_sel = ui_in[7];

  // Next-state: load overrides the prescaler; otherwise tick when pre reaches its limit.
  always_comb begin
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    wrap_d = wrap_q;
    if (mode == MODE_LOAD) begin
      cnt_d  = uio_in;
      pre_d  = '0;
      wrap_d = 1'b0;
    end else if (pre_q >= pre_lim) begin
      // >= rather than == so that lowering n mid-count forces an immediate tick.
      pre_d = '0;
      case (mode)
        MODE_UP: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'hFF) wrap_d = 1'b1;
        end
        MODE_DOWN: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'h00) wrap_d = 1'b1;
        end
        default: cnt_d = cnt_q;
      endcase
    end else begin
      pre_d = pre_q + 8'd1;
    end
  end

  // State registers with synchronous active-high reset on rst_n.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
    end
  end

  hex7seg u_hex7seg (
    .digit_i (cnt_q[3:0]),
    .seg_o   (seg)
  );

  // Display mux: raw count, or low hex digit with the wrap flag on bit 7.
  always_comb begin
    uo_out = disp_sel ? {wrap_q, seg} : cnt_q;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_wokwi_414120248222232577.sv
// Self-checking bench for the prescaled counter tile, with a behavioural model.
module tb_wokwi_414120248222232577;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int m_cnt = 0;
  int m_pre = 0;
  bit m_wrap = 1'b0;

  logic [7:0] seg_ref [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  wokwi_414120248222232577 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_out();
    logic [7:0] r;
    if (ui_in[7]) r = {m_wrap, seg_ref[m_cnt % 16][6:0]};
    else r = m_cnt[7:0];
    return r;
  endfunction

  // One clock edge: model follows the inputs present at the edge, then settle.
  task automatic step();
    int mode;
    int lim;
    @(posedge clk);
    mode = int'(ui_in[1:0]);
    lim  = (1 << int'(ui_in[4:2])) - 1;
    if (rst_n) begin
      m_cnt = 0; m_pre = 0; m_wrap = 1'b0;
    end else if (mode == 3) begin
      m_cnt = int'(uio_in); m_pre = 0; m_wrap = 1'b0;
    end else if (m_pre >= lim) begin
      m_pre = 0;
      if (mode == 1) begin
        if (m_cnt == 255) m_wrap = 1'b1;
        m_cnt = (m_cnt + 1) % 256;
      end else if (mode == 2) begin
        if (m_cnt == 0) m_wrap = 1'b1;
        m_cnt = (m_cnt + 255) % 256;
      end
    end else begin
      m_pre = m_pre + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
  endtask

  task automatic load(input logic [7:0] v);
    ui_in = 8'h03; uio_in = v;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ui_in = 8'h80; uio_in = 8'h00;
    step(); step();
    checks++;
    if (uo_out !== 8'h3F) begin errors++; $display("FAIL reset_seg got %h want 3F", uo_out); end
    ui_in = 8'h00; #1;
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_bin got %h want 00", uo_out); end
    checks++;
    if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      errors++; $display("FAIL reset_uio got oe=%h out=%h want 00/00", uio_oe, uio_out);
    end
  endtask

  task automatic test_count_up();
    ui_in = 8'h01;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (uo_out !== 8'h05) begin errors++; $display("FAIL count_up got %h want 05", uo_out); end
  endtask

  task automatic test_load_down();
    load(8'hA5);
    ui_in = 8'h02;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (uo_out !== 8'hA2) begin errors++; $display("FAIL load_down got %h want A2", uo_out); end
  endtask

  task automatic test_wrap();
    load(8'hFE);
    ui_in = 8'h81;
    step(); step();
    checks++;
    if (uo_out !== 8'hBF) begin errors++; $display("FAIL wrap_up got %h want BF", uo_out); end
    ui_in = 8'h01; #1;
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL wrap_cnt got %h want 00", uo_out); end
    ui_in = 8'h83; uio_in = 8'h12;
    step();
    checks++;
    if (uo_out !== 8'h5B) begin errors++; $display("FAIL wrap_clear got %h want 5B", uo_out); end
    load(8'h00);
    ui_in = 8'h82;
    step();
    checks++;
    if (uo_out !== 8'hF1) begin errors++; $display("FAIL wrap_down got %h want F1", uo_out); end
  endtask

  task automatic test_prescale();
    ui_in = 8'h0D;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (uo_out !== 8'(i / 8)) begin
        errors++; $display("FAIL prescale edge %0d got %h want %h", i, uo_out, 8'(i / 8));
      end
    end
  endtask

  task automatic test_reduce_n();
    ui_in = 8'h1D;
    do_reset();
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reduce_pre got %h want 00", uo_out); end
    ui_in = 8'h09;
    step();
    checks++;
    if (uo_out !== 8'h01) begin errors++; $display("FAIL reduce_force got %h want 01", uo_out); end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (uo_out !== 8'h02) begin errors++; $display("FAIL reduce_next got %h want 02", uo_out); end
  endtask

  task automatic test_hold();
    load(8'h3C);
    ui_in = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (uo_out !== 8'h3C) begin errors++; $display("FAIL hold edge %0d got %h want 3C", i, uo_out); end
    end
    ui_in = 8'h80; #1;
    checks++;
    if (uo_out !== 8'h39) begin errors++; $display("FAIL hold_seg got %h want 39", uo_out); end
  endtask

  task automatic test_reset_mid();
    ui_in = 8'h01;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1; ui_in = 8'h03; uio_in = 8'h77;
    step();
    rst_n = 1'b0; ui_in = 8'h00; #1;
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_mid got %h want 00", uo_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n  = ($urandom_range(0, 40) == 0);
      ui_in  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) ui_in[4] = 1'b0;
      if (ui_in[1:0] == 2'b11 && $urandom_range(0, 2) != 0) ui_in[1:0] = 2'($urandom_range(0, 2));
      uio_in = 8'($urandom);
      step();
      checks++;
      if (uo_out !== exp_out() || uio_oe !== 8'h00 || uio_out !== 8'h00) begin
        errors++;
        $display("FAIL random cycle %0d got %h want %h (oe=%h out=%h)", i, uo_out, exp_out(), uio_oe, uio_out);
      end
    end
  endtask

  initial begin
    ena = 1'b1; rst_n = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    test_reset();
    test_count_up();
    test_load_down();
    test_wrap();
    test_prescale();
    test_reduce_n();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
